// File: rtl/trap_sequencer.sv
// Execute-stage trap/interrupt sequencer: arbitrates exceptions, MRET and M-mode
// interrupts, strobes trap entry to the CSR file and redirects fetch.
module trap_sequencer #(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            exc_valid_i,
  input  logic [XLEN-1:0] exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_i,
  input  logic            commit_valid_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic            irq_sw_i,
  input  logic            irq_timer_i,
  input  logic            irq_ext_i,
  input  logic            mstatus_mie_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            redirect_ready_i,
  output logic            trap_active_o,
  output logic [XLEN-1:0] trap_cause_o,
  output logic [XLEN-1:0] trap_mepc_o,
  output logic [XLEN-1:0] trap_tval_o,
  output logic [XLEN-1:0] mip_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            busy_o
);

  // Redirect handshake: redirect_valid_o stays high with redirect_pc_o stable
  // until the cycle redirect_ready_i is high; that cycle completes the transfer.
  typedef enum logic [1:0] {IDLE, TRAP, REDIRECT} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_sw_q, sync_tm_q, sync_ext_q;
  logic [XLEN-1:0] cause_q, epc_q, tval_q, target_q, trap_target;
  logic            is_irq_q;
  logic [3:0]      code_q, irq_code;
  logic            pend_sw, pend_tm, pend_ext, irq_any;
  logic            idle_open, accept_exc, accept_mret, accept_irq;
  logic            unused_mie;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_sw_q  <= '0;
      sync_tm_q  <= '0;
      sync_ext_q <= '0;
    end else begin
      sync_sw_q  <= {sync_sw_q[SYNC_STAGES-2:0], irq_sw_i};
      sync_tm_q  <= {sync_tm_q[SYNC_STAGES-2:0], irq_timer_i};
      sync_ext_q <= {sync_ext_q[SYNC_STAGES-2:0], irq_ext_i};
    end
  end

  always_comb begin
    mip_o     = '0;
    mip_o[3]  = sync_sw_q[SYNC_STAGES-1];
    mip_o[7]  = sync_tm_q[SYNC_STAGES-1];
    mip_o[11] = sync_ext_q[SYNC_STAGES-1];
  end

  assign unused_mie = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

  assign pend_ext = mstatus_mie_i & mie_i[11] & mip_o[11];
  assign pend_sw  = mstatus_mie_i & mie_i[3]  & mip_o[3];
  assign pend_tm  = mstatus_mie_i & mie_i[7]  & mip_o[7];
  assign irq_any  = pend_ext | pend_sw | pend_tm;

  always_comb begin
    irq_code = 4'd7;
    if (pend_ext)     irq_code = 4'd11;
    else if (pend_sw) irq_code = 4'd3;
  end

  assign idle_open   = (state_q == IDLE) && !stall_i;
  assign accept_exc  = idle_open && exc_valid_i;
  assign accept_mret = idle_open && !exc_valid_i && mret_i;
  assign accept_irq  = idle_open && !exc_valid_i && !mret_i && commit_valid_i && irq_any;

  // Vectored mode only applies to interrupts; exceptions always use the base.
  always_comb begin
    trap_target = mtvec_i & ~XLEN'(3);
    if (mtvec_i[1:0] == 2'b01 && is_irq_q)
      trap_target = (mtvec_i & ~XLEN'(3)) + (XLEN'(code_q) << 2);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cause_q  <= '0;
      epc_q    <= '0;
      tval_q   <= '0;
      is_irq_q <= 1'b0;
      code_q   <= '0;
      target_q <= '0;
    end else begin
      if (accept_exc) begin
        cause_q  <= exc_cause_i;
        epc_q    <= exc_pc_i;
        tval_q   <= exc_tval_i;
        is_irq_q <= 1'b0;
        code_q   <= '0;
      end else if (accept_irq) begin
        cause_q  <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
        epc_q    <= commit_pc_i;
        tval_q   <= '0;
        is_irq_q <= 1'b1;
        code_q   <= irq_code;
      end
      if (accept_mret)
        target_q <= mepc_i;
      else if (state_q == TRAP)
        target_q <= trap_target;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_exc || accept_irq) state_d = TRAP;
        else if (accept_mret)         state_d = REDIRECT;
      end
      TRAP:     state_d = REDIRECT;
      REDIRECT: if (redirect_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    trap_active_o    = 1'b0;
    trap_cause_o     = '0;
    trap_mepc_o      = '0;
    trap_tval_o      = '0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    busy_o           = (state_q != IDLE);
    case (state_q)
      IDLE: flush_o = accept_mret;
      TRAP: begin
        trap_active_o = 1'b1;
        flush_o       = 1'b1;
        trap_cause_o  = cause_q;
        trap_mepc_o   = epc_q;
        trap_tval_o   = tval_q;
      end
      REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Execute-stage trap/interrupt sequencer directly upstream of the CSR register file.
- Arbitrates synchronous exceptions, M-mode interrupts and MRET, and produces the trap-entry strobe and cause/epc/tval the CSR file latches.
- Consumes mtvec/mepc/mstatus.MIE/mie back from the CSR file and issues a flush plus a redirect PC to fetch over a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width.
- SYNC_STAGES, 2, flop stages on each asynchronous interrupt input (minimum 2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- stall_i  in  1  pipeline stalled; new events not accepted while high
- exc_valid_i  in  1  synchronous exception present at commit point
- exc_cause_i  in  XLEN  exception cause code
- exc_pc_i  in  XLEN  PC of faulting instruction
- exc_tval_i  in  XLEN  exception tval
- mret_i  in  1  MRET at commit point
- commit_valid_i  in  1  valid instruction at commit point (interrupt may be taken)
- commit_pc_i  in  XLEN  PC of that instruction (interrupt epc)
- irq_sw_i, irq_timer_i, irq_ext_i  in  1 each  asynchronous interrupt lines
- mstatus_mie_i  in  1  global interrupt enable from CSR file
- mie_i  in  XLEN  mie from CSR file
- mtvec_i  in  XLEN  mtvec from CSR file
- mepc_i  in  XLEN  mepc from CSR file
- redirect_ready_i  in  1  fetch accepts redirect
- trap_active_o  out  1  one-cycle trap-entry strobe to CSR file
- trap_cause_o, trap_mepc_o, trap_tval_o  out  XLEN  trap payload, valid while trap_active_o
- mip_o  out  XLEN  synchronized pending bits (3=MSIP, 7=MTIP, 11=MEIP, others 0)
- flush_o  out  1  flush younger pipeline state
- redirect_valid_o  out  1  redirect request
- redirect_pc_o  out  XLEN  redirect target
- busy_o  out  1  sequencer not IDLE

Behaviour:
- Reset: state IDLE; every output 0; synchronizer chains and payload registers 0. Reset mid-operation aborts any trap/redirect immediately, with no partial strobe.
- Synchronizers: each irq line passes through SYNC_STAGES flops. mip_o reflects the last stage, so latency is SYNC_STAGES cycles from input edge to mip_o.
- Interrupt pending: pend = mstatus_mie_i & mie_i[k] & mip_o[k]. Priority is MEI(11) > MSI(3) > MTI(7).
- States: IDLE, TRAP, REDIRECT.
- IDLE acceptance: events are sampled only when stall_i=0. Priority is exception > MRET > interrupt (the interrupt additionally requires commit_valid_i=1).
  - Exception: cause=exc_cause_i, epc=exc_pc_i, tval=exc_tval_i; go to TRAP.
  - Interrupt: cause={1'b1, code zero-extended}, epc=commit_pc_i, tval=0; go to TRAP.
  - MRET: target=mepc_i; flush_o=1 in the acceptance cycle; go to REDIRECT. trap_active_o is not asserted for MRET.
- TRAP (exactly 1 cycle, independent of stall_i): trap_active_o=1, flush_o=1, payload outputs driven. Target is computed from mtvec_i sampled this cycle:
  - mtvec_i[1:0]==01 and interrupt: (mtvec_i & ~3) + 4*code.
  - Otherwise: mtvec_i & ~3.
  - Then go to REDIRECT.
- REDIRECT: redirect_valid_o=1 with stable redirect_pc_o until the cycle redirect_ready_i=1; then go to IDLE. Ready is allowed to be already high on entry, giving a 1-cycle REDIRECT.
- Outside IDLE: exc_valid_i, mret_i and interrupts are ignored (the pipeline is flushed); busy_o=1. Interrupt pending state is level-based and re-evaluated after return to IDLE.
- Latency: exception accepted at cycle N gives trap_active_o at N+1 and redirect_valid_o at N+2.
- Payload outputs are 0 when trap_active_o=0.
- Adder wraps modulo 2^XLEN; no overflow detection.

Test Plan:
- Reset release, idle inputs -> all outputs 0, busy_o=0, mip_o=0.
- exc_valid_i=1, cause=2, pc=0x100, tval=0xDEAD, mtvec_i=0x8000_0001, redirect_ready_i=1 -> trap_active_o pulse at N+1 with cause=2/mepc=0x100/tval=0xDEAD; redirect_pc_o=0x8000_0000 at N+2.
- irq_timer_i and irq_ext_i rise together, MIE=1, mie_i=0x888, mtvec_i=0x8000_0001, commit_pc_i=0x200 -> after SYNC_STAGES, trap_cause_o=0x8000_000B, mepc=0x200, redirect_pc_o=0x8000_002C.
- stall_i=1 for 5 cycles with exc_valid_i held -> no trap until stall_i=0. Then exc_valid_i and mret_i asserted together -> exception wins.
- mret_i=1, mepc_i=0x400, redirect_ready_i low for 3 cycles -> flush_o pulse, no trap_active_o, redirect_valid_o held with pc 0x400 for 4 cycles.
- rst_i asserted during REDIRECT -> redirect_valid_o and busy_o drop asynchronously; no trap strobe after release.
